// File: rtl/fetch_unit.sv
// Instruction-fetch stage: sequential PC generation, credit-limited word reads, an in-order
// response buffer tagged with PC and fault, and a redirect path that flushes stale fetches.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   output logic        mem_req_valid_o,
   input  logic        mem_req_ready_i,
   output logic [31:0] mem_req_addr_o,
   input  logic        mem_rsp_valid_i,
   input  logic [31:0] mem_rsp_data_i,
   input  logic        mem_rsp_error_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic        instr_fault_o,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam logic [CntW:0] DepthW = (CntW + 1)'(DEPTH);

   typedef logic [PtrW-1:0] ptr_t;
   typedef logic [CntW-1:0] cnt_t;

   logic [31:0] pc_q, pc_d;
   logic [31:0] rsp_pc_q, rsp_pc_d;
   ptr_t        rd_ptr_q, rd_ptr_d;
   ptr_t        wr_ptr_q, wr_ptr_d;
   cnt_t        count_q, count_d;
   cnt_t        outst_q, outst_d;
   cnt_t        discard_q, discard_d;

   logic [31:0] data_q  [DEPTH];
   logic [31:0] tag_q   [DEPTH];
   logic        fault_q [DEPTH];

   logic        accept;
   logic        drop;
   logic        push;
   logic        pop;
   logic [31:0] target_pc;
   logic        unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc_i[1:0];
   assign target_pc           = {redirect_pc_i[31:2], 2'b00};

   // Credit rule: buffered plus in-flight never exceeds DEPTH, so responses always fit.
   assign mem_req_valid_o = reset_ni & (({1'b0, count_q} + {1'b0, outst_q}) < DepthW);
   assign mem_req_addr_o  = pc_q;
   assign accept          = mem_req_valid_o & mem_req_ready_i;

   assign drop = (discard_q != '0) | redirect_i;
   assign push = mem_rsp_valid_i & ~drop;
   assign pop  = (count_q != '0) & instr_ready_i;

   assign instr_valid_o = (count_q != '0);
   assign instr_o       = data_q[rd_ptr_q];
   assign instr_pc_o    = tag_q[rd_ptr_q];
   assign instr_fault_o = fault_q[rd_ptr_q];

   always_comb begin
      pc_d      = pc_q;
      rsp_pc_d  = rsp_pc_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q + cnt_t'(push) - cnt_t'(pop);
      outst_d   = outst_q + cnt_t'(accept) - cnt_t'(mem_rsp_valid_i);
      discard_d = discard_q;

      if (accept) begin
         pc_d = pc_q + 32'd4;
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + ptr_t'(1);
         rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      if (mem_rsp_valid_i && (discard_q != '0)) begin
         discard_d = discard_q - cnt_t'(1);
      end

      // Everything still in flight after this cycle belongs to the old path.
      if (redirect_i) begin
         pc_d      = target_pc;
         rsp_pc_d  = target_pc;
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
         count_d   = '0;
         discard_d = outst_d;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         pc_q      <= RESET_PC;
         rsp_pc_q  <= RESET_PC;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         outst_q   <= '0;
         discard_q <= '0;
      end else begin
         pc_q      <= pc_d;
         rsp_pc_q  <= rsp_pc_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         outst_q   <= outst_d;
         discard_q <= discard_d;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i]  <= '0;
            tag_q[i]   <= '0;
            fault_q[i] <= 1'b0;
         end
      end else if (push) begin
         data_q[wr_ptr_q]  <= mem_rsp_data_i;
         tag_q[wr_ptr_q]   <= rsp_pc_q;
         fault_q[wr_ptr_q] <= mem_rsp_error_i;
      end
   end

   rsp_needs_outstanding: assert property (@(posedge clk_i) disable iff (!reset_ni)
      mem_rsp_valid_i |-> (outst_q != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: fixed-latency memory model, event logs and a
// sequential-PC reference stream that restarts at every redirect target.
module tb_fetch_unit;
   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0100;

   logic        clk;
   logic        reset_n;
   logic        mem_req_valid, mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        mem_rsp_error;
   logic        instr_valid, instr_ready;
   logic [31:0] instr, instr_pc;
   logic        instr_fault;
   logic        redirect;
   logic [31:0] redirect_pc;

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk_i          (clk),
      .reset_ni       (reset_n),
      .mem_req_valid_o(mem_req_valid),
      .mem_req_ready_i(mem_req_ready),
      .mem_req_addr_o (mem_req_addr),
      .mem_rsp_valid_i(mem_rsp_valid),
      .mem_rsp_data_i (mem_rsp_data),
      .mem_rsp_error_i(mem_rsp_error),
      .instr_valid_o  (instr_valid),
      .instr_ready_i  (instr_ready),
      .instr_o        (instr),
      .instr_pc_o     (instr_pc),
      .instr_fault_o  (instr_fault),
      .redirect_i     (redirect),
      .redirect_pc_i  (redirect_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: still running at %0t, limit 1000000", $time);
      $fatal(1, "timeout");
   end

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          lat = 1;
   int          mem_rdy_pct = 100;
   int          cons_rdy_pct = 100;
   logic [31:0] err_addr = 32'h3;
   bit          rand_err = 1'b0;
   bit          rd_req = 1'b0;
   logic [31:0] rd_pc = '0;

   logic [31:0] pend_addr[$];
   int          pend_due[$];
   logic [31:0] acc_addr[$];
   int          acc_cyc[$];
   logic [31:0] pop_pc[$];
   logic [31:0] pop_data[$];
   logic        pop_fault[$];
   int          pop_cyc[$];
   int          rd_cyc[$];
   logic [31:0] rd_tgt[$];

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic err_of(input logic [31:0] a);
      return (a == err_addr) || (rand_err && (a[6:2] == 5'd21));
   endfunction

   task automatic clear_logs();
      pend_addr.delete(); pend_due.delete();
      acc_addr.delete();  acc_cyc.delete();
      pop_pc.delete();    pop_data.delete(); pop_fault.delete(); pop_cyc.delete();
      rd_cyc.delete();    rd_tgt.delete();
   endtask

   task automatic idle_inputs();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_error = 1'b0;
      instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; rd_req = 1'b0;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      idle_inputs();
      clear_logs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      cyc = 0;
   endtask

   // One clock: drive inputs for the coming edge, log the handshakes that edge will take.
   task automatic step();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      mem_rsp_error = 1'b0;
      if (pend_due.size() > 0 && pend_due[0] == cyc + 1) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = data_of(pend_addr[0]);
         mem_rsp_error = err_of(pend_addr[0]);
         void'(pend_due.pop_front());
         void'(pend_addr.pop_front());
      end
      mem_req_ready = ($urandom_range(99) < mem_rdy_pct);
      instr_ready   = ($urandom_range(99) < cons_rdy_pct);
      redirect      = rd_req;
      redirect_pc   = rd_pc;
      if (rd_req) begin
         rd_cyc.push_back(cyc);
         rd_tgt.push_back(rd_pc);
      end
      rd_req = 1'b0;
      if (mem_req_valid && mem_req_ready) begin
         acc_addr.push_back(mem_req_addr);
         acc_cyc.push_back(cyc);
         pend_addr.push_back(mem_req_addr);
         pend_due.push_back(cyc + 1 + lat);
      end
      if (instr_valid && instr_ready) begin
         pop_pc.push_back(instr_pc);
         pop_data.push_back(instr);
         pop_fault.push_back(instr_fault);
         pop_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain();
      mem_rdy_pct  = 0;
      cons_rdy_pct = 100;
      repeat (lat + 12) step();
   endtask

   task automatic test_reset();
      #3;
      tests++; if (mem_req_valid !== 1'b0) begin fails++;
         $display("FAIL reset_req_valid: got %b want 0", mem_req_valid); end
      tests++; if (instr_valid !== 1'b0) begin fails++;
         $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
      tests++; if ({instr, instr_pc, instr_fault} !== 65'd0) begin fails++;
         $display("FAIL reset_instr_fields: got %h/%h/%b want 0", instr, instr_pc, instr_fault); end
      apply_reset();
      tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC) begin fails++;
         $display("FAIL reset_first_req: got %b/%h want 1/%h", mem_req_valid, mem_req_addr,
                  RESET_PC); end
      tests++; if (instr_valid !== 1'b0) begin fails++;
         $display("FAIL reset_release_empty: got %b want 0", instr_valid); end
   endtask

   task automatic test_stream();
      apply_reset();
      lat = 1; mem_rdy_pct = 100; cons_rdy_pct = 100;
      repeat (20) step();
      tests++; if (acc_addr.size() < 8 || pop_pc.size() < 10) begin fails++;
         $display("FAIL stream_counts: got acc %0d pop %0d want >=8 >=10", acc_addr.size(),
                  pop_pc.size()); end
      for (int i = 0; i < 8 && i < acc_addr.size(); i++) begin
         tests++; if (acc_addr[i] !== RESET_PC + 32'(4 * i) || acc_cyc[i] != i) begin fails++;
            $display("FAIL stream_req%0d: got %h@%0d want %h@%0d", i, acc_addr[i], acc_cyc[i],
                     RESET_PC + 32'(4 * i), i); end
      end
      for (int i = 0; i < 10 && i < pop_pc.size(); i++) begin
         tests++;
         if (pop_pc[i] !== RESET_PC + 32'(4 * i) || pop_cyc[i] != 2 + i ||
             pop_data[i] !== data_of(RESET_PC + 32'(4 * i)) || pop_fault[i] !== 1'b0) begin
            fails++;
            $display("FAIL stream_instr%0d: got pc %h data %h @%0d want pc %h data %h @%0d", i,
                     pop_pc[i], pop_data[i], pop_cyc[i], RESET_PC + 32'(4 * i),
                     data_of(RESET_PC + 32'(4 * i)), 2 + i);
         end
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      lat = 1; mem_rdy_pct = 100; cons_rdy_pct = 0;
      repeat (10) step();
      tests++; if (acc_addr.size() != DEPTH || mem_req_valid !== 1'b0) begin fails++;
         $display("FAIL bp_credit: got %0d reqs valid %b want %0d valid 0", acc_addr.size(),
                  mem_req_valid, DEPTH); end
      tests++; if (instr_valid !== 1'b1 || instr_pc !== RESET_PC || instr !== data_of(RESET_PC))
      begin fails++;
         $display("FAIL bp_head: got %b %h %h want 1 %h %h", instr_valid, instr_pc, instr,
                  RESET_PC, data_of(RESET_PC)); end
      cons_rdy_pct = 100;
      step();
      tests++; if (mem_req_valid !== 1'b1) begin fails++;
         $display("FAIL bp_reissue: got valid %b want 1", mem_req_valid); end
      repeat (20) step();
      drain();
      tests++; if (pop_pc.size() != acc_addr.size() || pop_pc.size() < 15) begin fails++;
         $display("FAIL bp_lost: got %0d pops for %0d reqs", pop_pc.size(), acc_addr.size()); end
      for (int i = 0; i < pop_pc.size(); i++) begin
         tests++;
         if (pop_pc[i] !== RESET_PC + 32'(4 * i) || pop_data[i] !== data_of(pop_pc[i])) begin
            fails++;
            $display("FAIL bp_order%0d: got pc %h data %h want pc %h", i, pop_pc[i], pop_data[i],
                     RESET_PC + 32'(4 * i));
         end
      end
   endtask

   task automatic test_req_stall();
      apply_reset();
      lat = 1; mem_rdy_pct = 100; cons_rdy_pct = 100;
      repeat (2) step();
      mem_rdy_pct = 0;
      for (int k = 0; k < 4; k++) begin
         tests++; if (mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC + 32'h8) begin fails++;
            $display("FAIL stall_hold%0d: got %b/%h want 1/%h", k, mem_req_valid, mem_req_addr,
                     RESET_PC + 32'h8); end
         if (k < 3) step();
      end
      mem_rdy_pct = 100;
      step();
      tests++; if (acc_addr.size() != 3 || acc_addr[2] !== RESET_PC + 32'h8 ||
                   mem_req_addr !== RESET_PC + 32'hC) begin fails++;
         $display("FAIL stall_resume: got %0d reqs next %h want 3 next %h", acc_addr.size(),
                  mem_req_addr, RESET_PC + 32'hC); end
   endtask

   task automatic test_redirect();
      int stale;
      apply_reset();
      lat = 5; mem_rdy_pct = 100; cons_rdy_pct = 100;
      for (int k = 0; k < 20 && pend_addr.size() != 3; k++) step();
      tests++; if (pend_addr.size() != 3) begin fails++;
         $display("FAIL redir_setup: got %0d outstanding want 3", pend_addr.size()); end
      rd_req = 1'b1; rd_pc = 32'h2003;
      step();
      tests++; if (mem_req_addr !== 32'h2000) begin fails++;
         $display("FAIL redir_addr: got %h want 00002000", mem_req_addr); end
      repeat (40) step();
      drain();
      stale = 0;
      foreach (acc_cyc[i]) if (acc_cyc[i] <= rd_cyc[0]) stale++;
      tests++; if (stale != 4 || acc_addr[stale] !== 32'h2000) begin fails++;
         $display("FAIL redir_req: got %0d stale then %h want 4 then 00002000", stale,
                  acc_addr[stale]); end
      tests++; if (pop_pc.size() != acc_addr.size() - stale) begin fails++;
         $display("FAIL redir_drop: got %0d pops want %0d", pop_pc.size(),
                  acc_addr.size() - stale); end
      for (int i = 0; i < pop_pc.size(); i++) begin
         tests++;
         if (pop_pc[i] !== 32'h2000 + 32'(4 * i) || pop_data[i] !== data_of(pop_pc[i])) begin
            fails++;
            $display("FAIL redir_instr%0d: got pc %h want %h", i, pop_pc[i],
                     32'h2000 + 32'(4 * i));
         end
      end
   endtask

   task automatic test_back_to_back();
      int          n_new;
      logic [31:0] exp_pc;
      apply_reset();
      lat = 3; mem_rdy_pct = 100; cons_rdy_pct = 100;
      repeat (2) step();
      rd_req = 1'b1; rd_pc = 32'h0000_0400;
      step();
      rd_req = 1'b1; rd_pc = 32'h0000_0803;
      step();
      repeat (20) step();
      drain();
      n_new = 0;
      foreach (acc_cyc[i]) if (acc_cyc[i] > rd_cyc[1]) n_new++;
      tests++; if (pop_pc.size() != n_new || n_new == 0) begin fails++;
         $display("FAIL b2b_count: got %0d pops want %0d", pop_pc.size(), n_new); end
      exp_pc = 32'h800;
      for (int i = 0; i < pop_pc.size(); i++) begin
         tests++; if (pop_pc[i] !== exp_pc || pop_data[i] !== data_of(exp_pc)) begin fails++;
            $display("FAIL b2b_instr%0d: got pc %h want %h", i, pop_pc[i], exp_pc); end
         exp_pc += 32'd4;
      end
   endtask

   task automatic test_fault();
      bit seen;
      apply_reset();
      lat = 1; mem_rdy_pct = 100; cons_rdy_pct = 100; err_addr = 32'h8;
      rd_req = 1'b1; rd_pc = 32'h0;
      step();
      repeat (15) step();
      drain();
      seen = 1'b0;
      for (int i = 0; i < pop_pc.size(); i++) begin
         tests++;
         if (pop_pc[i] !== 32'(4 * i) || pop_fault[i] !== (pop_pc[i] == 32'h8)) begin fails++;
            $display("FAIL fault_entry%0d: got pc %h fault %b want pc %h fault %b", i, pop_pc[i],
                     pop_fault[i], 32'(4 * i), (32'(4 * i) == 32'h8));
         end
         if (pop_pc[i] == 32'h8 && pop_fault[i] === 1'b1) seen = 1'b1;
      end
      tests++; if (!seen) begin fails++;
         $display("FAIL fault_seen: got no faulting pc 00000008 want one"); end
      err_addr = 32'h3;
   endtask

   task automatic test_wrap();
      logic [31:0] want [3];
      int          first;
      want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0;
      apply_reset();
      lat = 2; mem_rdy_pct = 100; cons_rdy_pct = 100;
      rd_req = 1'b1; rd_pc = 32'hFFFF_FFF8;
      step();
      repeat (12) step();
      drain();
      first = 0;
      foreach (acc_cyc[i]) if (acc_cyc[i] <= rd_cyc[0]) first++;
      for (int i = 0; i < 3; i++) begin
         tests++; if (acc_addr[first + i] !== want[i] || pop_pc[i] !== want[i] ||
                      pop_data[i] !== data_of(want[i])) begin fails++;
            $display("FAIL wrap%0d: got req %h pc %h want %h", i, acc_addr[first + i],
                     pop_pc[i], want[i]); end
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      lat = 1; mem_rdy_pct = 100; cons_rdy_pct = 100;
      repeat (8) step();
      #2;
      reset_n = 1'b0;
      #1;
      tests++; if (mem_req_valid !== 1'b0 || instr_valid !== 1'b0 ||
                   {instr, instr_pc, instr_fault} !== 65'd0) begin fails++;
         $display("FAIL async_reset: got %b %b %h %h %b want all 0", mem_req_valid, instr_valid,
                  instr, instr_pc, instr_fault); end
      apply_reset();
      tests++; if (mem_req_addr !== RESET_PC || instr_valid !== 1'b0) begin fails++;
         $display("FAIL async_restart: got %h %b want %h 0", mem_req_addr, instr_valid,
                  RESET_PC); end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc;
      int          k, r_last, n_acc, n_pop;
      for (int round = 0; round < 6; round++) begin
         apply_reset();
         lat = $urandom_range(1, 4);
         mem_rdy_pct = $urandom_range(40, 100);
         cons_rdy_pct = $urandom_range(30, 100);
         rand_err = 1'b1;
         repeat (150) begin
            if ($urandom_range(99) < 4) begin
               rd_req = 1'b1;
               rd_pc = $urandom_range(1) ? $urandom() : (32'hFFFF_FFF0 | $urandom_range(15));
            end
            step();
         end
         drain();
         exp_pc = RESET_PC; k = 0;
         for (int i = 0; i < acc_addr.size(); i++) begin
            while (k < rd_tgt.size() && rd_cyc[k] < acc_cyc[i]) begin
               exp_pc = rd_tgt[k] & 32'hFFFF_FFFC; k++;
            end
            tests++; if (acc_addr[i] !== exp_pc) begin fails++;
               $display("FAIL rand%0d_req%0d: got %h want %h", round, i, acc_addr[i], exp_pc); end
            exp_pc += 32'd4;
         end
         exp_pc = RESET_PC; k = 0;
         for (int i = 0; i < pop_pc.size(); i++) begin
            while (k < rd_tgt.size() && rd_cyc[k] < pop_cyc[i]) begin
               exp_pc = rd_tgt[k] & 32'hFFFF_FFFC; k++;
            end
            tests++; if (pop_pc[i] !== exp_pc || pop_data[i] !== data_of(exp_pc) ||
                         pop_fault[i] !== err_of(exp_pc)) begin fails++;
               $display("FAIL rand%0d_instr%0d: got %h/%h/%b want %h/%h/%b", round, i, pop_pc[i],
                        pop_data[i], pop_fault[i], exp_pc, data_of(exp_pc), err_of(exp_pc)); end
            exp_pc += 32'd4;
         end
         r_last = (rd_cyc.size() > 0) ? rd_cyc[rd_cyc.size() - 1] : -1;
         n_acc = 0; n_pop = 0;
         foreach (acc_cyc[i]) if (acc_cyc[i] > r_last) n_acc++;
         foreach (pop_cyc[i]) if (pop_cyc[i] > r_last) n_pop++;
         tests++; if (n_acc != n_pop) begin fails++;
            $display("FAIL rand%0d_complete: got %0d pops want %0d", round, n_pop, n_acc); end
         rand_err = 1'b0;
      end
   endtask

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      test_reset();
      test_stream();
      test_backpressure();
      test_req_stall();
      test_redirect();
      test_back_to_back();
      test_fault();
      test_wrap();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
